pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 132 +++++++++++++
 tb/tb_pc_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter for a single-cycle fetch path.
// Selects the next fetch address from the current instruction's control
// fields, rejects illegal targets, and halts on the first rejected target
// until reset. Also counts accepted PC advances.
module pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  npc_op,
    input  logic [25:0] ins25,
    input  logic [15:0] imm,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        fault,
    output logic [31:0] fetch_cnt
);

    // Next-PC select encoding carried by npc_op.
    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_J    = 3'd3,
        OP_JR   = 3'd4,
        OP_BGEZ = 3'd5,
        OP_BLTZ = 3'd6,
        OP_RSVD = 3'd7
    } npc_op_e;

    // RUN accepts legal targets; HALT freezes the PC until reset.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] next_pc;
    logic        br_taken;
    logic        next_illegal;
    npc_op_e     op;

    assign op = npc_op_e'(npc_op);

    // Address arithmetic: all sums wrap modulo 2^32.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        pc_plus8  = pc_q + 32'd8;
        br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        j_target  = {pc_plus4[31:28], ins25, 2'b00};
    end

    // Branch condition and next-PC mux; unknown ops fall back to sequential.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave it unassigned (latch).
        br_taken = 1'b0;
        next_pc  = pc_plus4;
        unique case (op)
            OP_BEQ:  br_taken = (rs_data == rt_data);
            OP_BNE:  br_taken = (rs_data != rt_data);
            OP_BGEZ: br_taken = ~rs_data[31];
            OP_BLTZ: br_taken = rs_data[31];
            OP_J:    next_pc  = j_target;
            OP_JR:   next_pc  = rs_data;
            OP_SEQ, OP_RSVD: ;
            default: ;
        endcase
        if (br_taken) begin
            next_pc = br_target;
        end
    end

    // Legal targets are word-aligned and inside [PC_RESET, PC_LIMIT].
    always_comb begin
        next_illegal = (next_pc[1:0] != 2'b00) ||
                       (next_pc < PC_RESET)    ||
                       (next_pc > PC_LIMIT);
    end

    // Next-state logic: advance on a legal target, halt on an illegal one,
    // hold on stall or while halted.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (en) begin
                    if (next_illegal) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d  = next_pc;
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_HALT;
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled at the same edge.
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign fetch_cnt = cnt_q;
    assign fault     = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
// Inputs change #1 after a rising edge; outputs are sampled at the same
// point, well away from the next active edge.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  npc_op;
    logic [25:0] ins25;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        fault;
    logic [31:0] fetch_cnt;

    int checks;
    int errors;

    pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .npc_op    (npc_op),
        .ins25     (ins25),
        .imm       (imm),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .pc        (pc),
        .pc_plus8  (pc_plus8),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge; inputs and samples settle #1 after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_pc,
                               input logic [31:0] exp_cnt, input logic exp_fault);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".cnt"}, fetch_cnt, exp_cnt);
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, exp_fault});
    endtask

    task automatic set_in(input logic e, input logic [2:0] op, input logic [15:0] i,
                          input logic [31:0] rs, input logic [31:0] rt);
        en      = e;
        npc_op  = op;
        imm     = i;
        rs_data = rs;
        rt_data = rt;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        ins25   = 26'd0;
        // Reset wins over an enabled jump request.
        set_in(1'b1, 3'd3, 16'h0000, 32'h0, 32'h0);
        ins25 = 26'h0000C40;
        step();
        check_state("reset", 32'h3000, 32'd0, 1'b0);
        check("reset.pc_plus8", pc_plus8, 32'h3008);

        // Sequential fetch.
        reset = 1'b0;
        set_in(1'b1, 3'd0, 16'h0000, 32'h0, 32'h0);
        step(); check_state("seq1", 32'h3004, 32'd1, 1'b0);
        step(); check_state("seq2", 32'h3008, 32'd2, 1'b0);
        step(); check_state("seq3", 32'h300C, 32'd3, 1'b0);
        check("seq3.pc_plus8", pc_plus8, 32'h3014);

        // beq taken, backward offset, from 3008.
        set_in(1'b1, 3'd4, 16'h0000, 32'h3008, 32'h0);
        step(); check_state("jr3008a", 32'h3008, 32'd4, 1'b0);
        set_in(1'b1, 3'd1, 16'hFFFE, 32'd5, 32'd5);
        step(); check_state("beq_taken", 32'h3004, 32'd5, 1'b0);
        // beq not taken from 3008.
        set_in(1'b1, 3'd0, 16'h0000, 32'd0, 32'd0);
        step(); check_state("seq4", 32'h3008, 32'd6, 1'b0);
        set_in(1'b1, 3'd1, 16'hFFFE, 32'd5, 32'd6);
        step(); check_state("beq_not", 32'h300C, 32'd7, 1'b0);
        // bne taken from 3008.
        set_in(1'b1, 3'd4, 16'h0000, 32'h3008, 32'h0);
        step(); check_state("jr3008b", 32'h3008, 32'd8, 1'b0);
        set_in(1'b1, 3'd2, 16'h0003, 32'd5, 32'd6);
        step(); check_state("bne_taken", 32'h3018, 32'd9, 1'b0);

        // Jump and jr from 3010.
        set_in(1'b1, 3'd4, 16'h0000, 32'h3010, 32'h0);
        step(); check_state("jr3010", 32'h3010, 32'd10, 1'b0);
        check("j.pc_plus8", pc_plus8, 32'h3018);
        set_in(1'b1, 3'd3, 16'h0000, 32'h0, 32'h0);
        ins25 = 26'h0000C40;
        step(); check_state("j", 32'h3100, 32'd11, 1'b0);
        set_in(1'b1, 3'd4, 16'h0000, 32'h3020, 32'h0);
        step(); check_state("jr3020", 32'h3020, 32'd12, 1'b0);

        // Signed compares, imm=4 so taken target = pc+4+16.
        set_in(1'b1, 3'd5, 16'h0004, 32'h8000_0000, 32'h0);
        step(); check_state("bgez_neg", 32'h3024, 32'd13, 1'b0);
        set_in(1'b1, 3'd6, 16'h0004, 32'h8000_0000, 32'h0);
        step(); check_state("bltz_neg", 32'h3038, 32'd14, 1'b0);
        set_in(1'b1, 3'd5, 16'h0004, 32'h0, 32'h0);
        step(); check_state("bgez_zero", 32'h304C, 32'd15, 1'b0);
        // Reserved op acts as sequential, even with a branch-like setup.
        set_in(1'b1, 3'd7, 16'h0004, 32'h1, 32'h1);
        step(); check_state("op7", 32'h3050, 32'd16, 1'b0);

        // Stall with a taken beq pending.
        set_in(1'b0, 3'd1, 16'h0002, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(); check_state("stall", 32'h3050, 32'd16, 1'b0);
        end
        en = 1'b1;
        step(); check_state("stall_release", 32'h305C, 32'd17, 1'b0);
        // Illegal target while stalled must not fault.
        set_in(1'b0, 3'd4, 16'h0000, 32'h3002, 32'h0);
        step(); check_state("stall_illegal", 32'h305C, 32'd17, 1'b0);

        // Misaligned jr -> halt, then HALT holds with legal requests.
        en = 1'b1;
        step(); check_state("misalign", 32'h305C, 32'd17, 1'b1);
        set_in(1'b1, 3'd4, 16'h0000, 32'h3100, 32'h0);
        step(); check_state("halt_hold1", 32'h305C, 32'd17, 1'b1);
        set_in(1'b1, 3'd0, 16'h0000, 32'h0, 32'h0);
        step(); check_state("halt_hold2", 32'h305C, 32'd17, 1'b1);
        reset = 1'b1;
        step(); check_state("reset_halt1", 32'h3000, 32'd0, 1'b0);
        reset = 1'b0;

        // jr below PC_RESET.
        set_in(1'b1, 3'd4, 16'h0000, 32'h2FFC, 32'h0);
        step(); check_state("below", 32'h3000, 32'd0, 1'b1);
        set_in(1'b1, 3'd0, 16'h0000, 32'h0, 32'h0);
        step(); check_state("below_hold", 32'h3000, 32'd0, 1'b1);
        reset = 1'b1;
        step(); check_state("reset_halt2", 32'h3000, 32'd0, 1'b0);
        reset = 1'b0;

        // jr to PC_LIMIT is legal; sequential fetch from there is not.
        set_in(1'b1, 3'd4, 16'h0000, 32'h3FFC, 32'h0);
        step(); check_state("jr_limit", 32'h3FFC, 32'd1, 1'b0);
        check("limit.pc_plus8", pc_plus8, 32'h4004);
        set_in(1'b1, 3'd0, 16'h0000, 32'h0, 32'h0);
        step(); check_state("seq_past_limit", 32'h3FFC, 32'd1, 1'b1);
        step(); check_state("limit_hold", 32'h3FFC, 32'd1, 1'b1);
        reset = 1'b1;
        step(); check_state("reset_halt3", 32'h3000, 32'd0, 1'b0);
        reset = 1'b0;

        // jr to exactly PC_RESET is legal.
        set_in(1'b1, 3'd4, 16'h0000, 32'h3000, 32'h0);
        step(); check_state("jr_reset_addr", 32'h3000, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
